// File: rtl/apb_cmd_master_if.sv
// Command/response and APB bus bundle for apb_cmd_master.
// master = the requester block, slave = the side that drives commands and models the completer.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB requester: takes one command, runs SETUP/ACCESS with an
// optional wait-state timeout, and holds the response until it is consumed.
module apb_cmd_master #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic               PCLK,
    input logic               PRESET,
    apb_cmd_master_if.master  bus
);
    // Counter only has to reach TIMEOUT; with the timeout disabled it may wrap freely.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic [CW-1:0]     wait_inc;

    assign wait_inc = wait_q + CW'(1);

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    write_d = bus.cmd_write;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rdata_d = write_q ? '0 : bus.PRDATA;
                    err_d   = bus.PSLVERR;
                    tmo_d   = 1'b0;
                    state_d = RESP;
                end else if ((TIMEOUT > 0) && (wait_inc == TO_VAL)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_inc;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.PSEL        = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.PENABLE     = (state_q == ACCESS);
    assign bus.PWRITE      = write_q;
    assign bus.PADDR       = addr_q;
    assign bus.PWDATA      = wdata_q;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = tmo_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Transaction-level bench: each command's outcome (access length, error, timeout,
// read data) is predicted from wait states, PSLVERR and TIMEOUT, then compared.
module tb_apb_cmd_master;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRESET;
    int   checks   = 0;
    int   failures = 0;

    apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
    task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits, input bit serr, input logic [DW-1:0] prd,
                           input int rdly);
        bit            exp_to;
        int            exp_len;
        logic [DW-1:0] exp_pwd;
        logic [DW-1:0] exp_rd;
        int            acc;
        int            bad;
        exp_to  = (TO > 0) && (waits >= TO);
        exp_len = exp_to ? TO : waits + 1;
        exp_pwd = wr ? d : '0;
        exp_rd  = (wr || exp_to) ? '0 : prd;

        chk("idle_ready", {bus.cmd_ready, bus.busy}, 2'b10);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.PREADY    = 1'($urandom);
        bus.PSLVERR   = 1'($urandom);
        @(negedge PCLK);
        chk("setup_ctl", {bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.busy, bus.rsp_valid}, 5'b10010);
        chk("setup_bus", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {wr, a, exp_pwd});
        // Keep offering junk commands; none may be taken before the block is idle again.
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = $urandom;
        bus.PREADY    = 1'($urandom);
        bus.PSLVERR   = 1'($urandom);
        acc = 0;
        bad = 0;
        while (1) begin
            @(negedge PCLK);
            if (!bus.PENABLE || acc >= 40) break;
            if (!bus.PSEL || bus.PADDR !== a || bus.PWRITE !== wr || bus.PWDATA !== exp_pwd ||
                bus.rsp_valid || bus.cmd_ready) bad++;
            bus.PREADY  = (acc >= waits);
            bus.PSLVERR = bus.PREADY ? serr : 1'($urandom);
            bus.PRDATA  = bus.PREADY ? prd : $urandom;
            acc++;
        end
        chk("access_len", acc, exp_len);
        chk("access_stable", bad, 0);
        bus.PREADY  = 1'($urandom);
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = $urandom;
        for (int i = 0; i <= rdly; i++) begin
            chk("resp_ctl", {bus.rsp_valid, bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.busy}, 5'b10001);
            chk("resp_data", {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, {exp_to | serr, exp_to, exp_rd});
            bus.rsp_ready = (i == rdly);
            @(negedge PCLK);
        end
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("back_idle", {bus.rsp_valid, bus.cmd_ready, bus.busy, bus.PSEL}, 4'b0100);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        PRESET        = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("rst_ctl", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.busy, bus.cmd_ready}, 6'b000001);
        chk("rst_bus", {bus.PADDR, bus.PWDATA}, '0);
        chk("rst_rsp", {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, '0);

        run_txn(1'b1, 6'h04, 32'hDEADBEEF, 0,  1'b0, 32'h0,        0);
        run_txn(1'b0, 6'h10, 32'h0,        3,  1'b0, 32'hA5A5A5A5, 0);
        run_txn(1'b0, 6'h2A, 32'h0,        1,  1'b1, 32'h12345678, 1);
        run_txn(1'b0, 6'h3F, 32'h0,        40, 1'b0, 32'h5555AAAA, 2);
        run_txn(1'b0, 6'h01, 32'h0,        15, 1'b0, 32'hCAFEF00D, 0);
        run_txn(1'b1, 6'h22, 32'h0BADF00D, 2,  1'b0, 32'h0,        5);

        for (int n = 0; n < 40; n++) begin
            bit            wr;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [DW-1:0] prd;
            int            waits;
            wr    = 1'($urandom);
            a     = AW'($urandom);
            d     = $urandom;
            prd   = $urandom;
            waits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 5));
            run_txn(wr, a, d, waits, ($urandom_range(0, 3) == 0), prd, int'($urandom_range(0, 5)));
        end

        // Reset in the middle of an ACCESS with PREADY held low.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 6'h15;
        bus.cmd_wdata = 32'h13572468;
        bus.PREADY    = 1'b0;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("pre_rst_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("mid_rst_ctl", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.busy}, 4'b0000);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("post_rst_ctl", {bus.cmd_ready, bus.busy, bus.rsp_valid}, 3'b100);
        chk("post_rst_bus", {bus.PWRITE, bus.PADDR, bus.PWDATA}, '0);
        run_txn(1'b0, 6'h07, 32'h0, 0, 1'b0, 32'h600DCAFE, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 The block SHALL use one clock, PCLK; reset is PRESET, synchronous and active-high.
REQ-002 Parameter ADDR_W SHALL default to 6 and set the command address and PADDR width.
REQ-003 Parameter DATA_W SHALL default to 32 and set the data width.
REQ-004 Parameter TIMEOUT SHALL default to 16 and give the maximum number of ACCESS cycles with PREADY low; 0 disables the timeout.
REQ-005 PCLK  in  1  clock.
REQ-006 PRESET  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  a command is offered.
REQ-008 cmd_ready  out  1  the block accepts a command.
REQ-009 cmd_write  in  1  1=write, 0=read.
REQ-010 cmd_addr  in  ADDR_W  transfer address.
REQ-011 cmd_wdata  in  DATA_W  write data.
REQ-012 rsp_valid  out  1  a response is available.
REQ-013 rsp_ready  in  1  the response is consumed.
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes and aborts.
REQ-015 rsp_err  out  1  PSLVERR or timeout occurred.
REQ-016 rsp_timeout  out  1  the transfer was aborted by timeout.
REQ-017 PSEL, PENABLE, PWRITE  out  1 each  APB requester controls.
REQ-018 PADDR  out  ADDR_W.
REQ-019 PWDATA  out  DATA_W  APB write data.
REQ-020 PRDATA  in  DATA_W  APB read data.
REQ-021 PREADY, PSLVERR  in  1 each  APB completer status.
REQ-022 busy  out  1  asserted whenever state != IDLE.

Function
REQ-023 The FSM SHALL have exactly four states: IDLE, SETUP, ACCESS, RESP; all outputs SHALL be registered or decoded from state and registers only.
REQ-024 cmd_ready SHALL equal (state==IDLE); a handshake (cmd_valid&cmd_ready) at edge N SHALL capture cmd_write/addr/wdata and enter SETUP.
REQ-025 SETUP SHALL last exactly one cycle: PSEL=1, PENABLE=0; the block SHALL then enter ACCESS.
REQ-026 ACCESS SHALL drive PSEL=1 and PENABLE=1, and SHALL stay in ACCESS while PREADY=0.
REQ-027 PADDR, PWRITE and PWDATA SHALL hold the captured values, stable from SETUP through the last ACCESS cycle; PWDATA SHALL be 0 for reads.
REQ-028 On ACCESS with PREADY=1, the block SHALL latch rsp_rdata=PRDATA for a read (0 for a write), latch rsp_err=PSLVERR and rsp_timeout=0, then enter RESP.
REQ-029 The wait counter SHALL clear on SETUP and increment on each ACCESS cycle with PREADY=0.
REQ-030 If TIMEOUT>0 and the wait counter reaches TIMEOUT while PREADY=0, the block SHALL abort and enter RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-031 PREADY=1 in the same cycle the counter would reach TIMEOUT SHALL count as normal completion, not timeout.
REQ-032 The counter SHALL be wide enough to hold TIMEOUT without wrap-around.
REQ-033 In IDLE and RESP, PSEL and PENABLE SHALL be 0.
REQ-034 RESP SHALL assert rsp_valid and hold rsp_* stable until rsp_ready=1, then return to IDLE.
REQ-035 A new command SHALL be accepted no earlier than the cycle after the RESP handshake (one IDLE cycle minimum).
REQ-036 Minimum latency: command accepted at edge N -> SETUP in cycle N+1 -> ACCESS in cycle N+2 -> rsp_valid in cycle N+3 when PREADY=1 with zero wait states.
REQ-037 PREADY and PSLVERR SHALL be ignored outside ACCESS.

Reset
REQ-038 With PRESET=1 at a PCLK edge, the block SHALL enter IDLE and clear all registers: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, busy=0, cmd_ready=1 (after release).
REQ-039 A reset asserted mid-transfer (SETUP, ACCESS or RESP) SHALL drop PSEL/PENABLE at that edge and discard the transfer and any pending response.

Verification
REQ-040 Write addr 0x04, data 0xDEADBEEF, PREADY=1 -> PSEL high 2 cycles, PWDATA=0xDEADBEEF, rsp_valid at N+3, rsp_err=0.
REQ-041 Read addr 0x10, PREADY low 3 cycles, PRDATA=0xA5A5A5A5 -> ACCESS lasts 4 cycles with PADDR stable, rsp_rdata=0xA5A5A5A5.
REQ-042 Read with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0.
REQ-043 PREADY held 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-044 rsp_ready low 5 cycles with cmd_valid high -> rsp_valid and data held, cmd_ready=0; after the handshake, the next command is accepted one cycle later.
REQ-045 PRESET pulsed during ACCESS -> PSEL=PENABLE=0 and rsp_valid=0 next cycle, cmd_ready=1 after release.
